shift_issue: RTL

//  Sequencing stage wrapped around the combinational 32-bit shifter in the datapath ALU.

---
 rtl/shift_issue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shift_issue.sv
// shift_issue: sequencing stage around the datapath's combinational 32-bit shifter.
// Accepts a shift/rotate request, drives the shifter from latched operands, registers
// the (possibly overridden) result plus flags and hands it downstream.
// Optional feature macro: SHIFT_CARRY_EN builds the out_carry (last bit shifted out) path;
// without it out_carry is tied to 0.
module shift_issue #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [2:0]        in_op,
    output logic [DATA_W-1:0] sh_in,
    output logic [AMT_W-1:0]  sh_amt,
    output logic              sh_right,
    output logic              sh_rotate,
    output logic              sh_arith,
    input  logic [DATA_W-1:0] sh_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_err,
    output logic              out_carry
);

    localparam logic [2:0] OP_SHR  = 3'd0;
    localparam logic [2:0] OP_SHRA = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_ROR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t              state_q, state_d;
    logic                rdy_q;
    logic [DATA_W-1:0]   data_q;
    logic [AMT_W-1:0]    amt_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                zero_q, neg_q, err_q;
    logic                accept, active, legal, is_rot, big;
    logic [4:0]          eff_amt;

    // rdy_q keeps in_ready low while reset is held and for the release cycle
    assign in_ready = rdy_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign active   = (state_q != IDLE);

    // Decode of the latched request; shifts by >=32 bypass the shifter entirely
    assign legal   = (op_q <= OP_ROL);
    assign is_rot  = (op_q == OP_ROR) | (op_q == OP_ROL);
    assign big     = legal & ~is_rot & (amt_q[AMT_W-1:5] != '0);
    assign eff_amt = (!legal || big) ? 5'd0 : amt_q[4:0];

    assign sh_in     = active ? data_q : '0;
    assign sh_amt    = active ? {{(AMT_W-5){1'b0}}, eff_amt} : '0;
    assign sh_right  = active & legal & ((op_q == OP_SHR) | (op_q == OP_SHRA) | (op_q == OP_ROR));
    assign sh_rotate = active & legal & is_rot;
    assign sh_arith  = active & (op_q == OP_SHRA);

    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
    assign out_err   = err_q;

    // Final result: illegal or zero-amount requests pass the operand through
    always_comb begin
        res_d = sh_out;
        if (!legal)
            res_d = data_q;
        else if (big)
            res_d = (op_q == OP_SHRA) ? {DATA_W{data_q[DATA_W-1]}} : '0;
        else if (eff_amt == 5'd0)
            res_d = data_q;
    end

    // Next-state logic for the IDLE/EXEC/DONE sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Input readiness only comes up one clock after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    // Operand latch on an accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            amt_q  <= '0;
            op_q   <= '0;
        end else if (accept) begin
            data_q <= in_data;
            amt_q  <= in_amt;
            op_q   <= in_op;
        end
    end

    // Result and flags captured at the end of EXEC; error clears on the next accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            res_q  <= res_d;
            zero_q <= (res_d == '0);
            neg_q  <= res_d[DATA_W-1];
            err_q  <= ~legal;
        end else if (accept) begin
            err_q  <= 1'b0;
        end
    end

`ifdef SHIFT_CARRY_EN
    logic                carry_q, carry_d;
    logic [4:0]          amt_m1;
    logic [DATA_W-1:0]   shl_t, shr_t;

    assign amt_m1 = eff_amt - 5'd1;
    assign shl_t  = data_q << amt_m1;
    assign shr_t  = data_q >> amt_m1;

    // Last bit shifted out; nothing leaves on a zero amount or illegal opcode
    always_comb begin
        carry_d = 1'b0;
        if (legal && (big || eff_amt != 5'd0)) begin
            case (op_q)
                OP_SHL:  carry_d = big ? 1'b0 : shl_t[DATA_W-1];
                OP_SHR:  carry_d = big ? 1'b0 : shr_t[0];
                OP_SHRA: carry_d = big ? data_q[DATA_W-1] : shr_t[0];
                OP_ROR:  carry_d = res_d[DATA_W-1];
                OP_ROL:  carry_d = res_d[0];
                default: carry_d = 1'b0;
            endcase
        end
    end

    // Carry register travels with the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               carry_q <= 1'b0;
        else if (state_q == EXEC)   carry_q <= carry_d;
    end

    assign out_carry = carry_q;
`else
    assign out_carry = 1'b0;
`endif

endmodule
